jump_pc_sequencer: RTL and testbench
====================================

// Module: jump_pc_sequencer
// PURPOSE
//  Multicycle next-PC controller for the Lab 3 MIPS core: owns the PC, drives instruction fetch, and sequences each instruction as FETCH->DECODE->EXECUTE->UPDATE.
//  Builds the jump target {pc_plus4[31:28], ir[25:0], 2'b00}, the branch target and the JR target internally.
//  Issues the $ra link write for JAL. Sits between instruction memory and the datapath/ALU.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value loaded on reset; must be word-aligned.
// PORTS
//  clk           in   1   rising-edge clock
//  reset_n       in   1   asynchronous, active-low reset
//  imem_addr     out  32  fetch address; always equals pc
//  imem_req      out  1   fetch request; high only in FETCH
//  imem_ready    in   1   imem_data valid this cycle; sampled only in FETCH
//  imem_data     in   32  fetched instruction
//  ir            out  32  latched instruction register
//  instr_valid   out  1   one-cycle pulse in DECODE; ir is valid for the datapath
//  ex_done       in   1   datapath finished execute; sampled only in EXECUTE
//  branch_taken  in   1   branch condition result; sampled with ex_done for BEQ/BNE only
//  reg_rs        in   32  rs register value, used as the JR target
//  ra_we         out  1   $ra write enable; one-cycle pulse in UPDATE for JAL
//  ra_data       out  32  link value = pc_plus4 of the JAL
//  pc            out  32  current program counter
//  addr_err      out  1   one-cycle pulse in UPDATE when the JR target has [1:0] != 0
// BEHAVIOUR
//  Reset (async assert; release takes effect on the next clk edge):
//   state=FETCH, pc=RESET_PC, ir=0; instr_valid, ra_we, addr_err = 0; ra_data=0.
//  Decode fields: opcode=ir[31:26], funct=ir[5:0].
//   J=6'h02, JAL=6'h03, BEQ=6'h04, BNE=6'h05, JR = opcode 0 with funct 6'h08.
//  pc_plus4 = pc + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
//  Targets:
//   jump   = {pc_plus4[31:28], ir[25:0], 2'b00}
//   branch = pc_plus4 + {{14{ir[15]}}, ir[15:0], 2'b00}, modulo 2^32
//   jr     = {reg_rs[31:2], 2'b00}
//  FSM (2-bit state):
//   FETCH:   imem_req=1. Stay while !imem_ready.
//            On imem_ready: ir<=imem_data, go to DECODE.
//   DECODE:  instr_valid=1 for exactly this cycle. Go to EXECUTE unconditionally.
//   EXECUTE: hold pc and ir. Stay while !ex_done.
//            On ex_done: capture branch_taken into an internal flag, go to UPDATE.
//   UPDATE:  one cycle. Load next pc, then go to FETCH.
//            J / JAL        -> jump target
//            JR             -> jr target
//            BEQ/BNE taken  -> branch target
//            all other cases (incl. branch not taken) -> pc_plus4
//            JAL: ra_we=1, ra_data=pc_plus4 (pre-update pc).
//            JR with reg_rs[1:0]!=0: addr_err=1; pc is still loaded with the masked target.
//  Latency: minimum 4 cycles per instruction (imem_ready and ex_done both high on arrival).
//   Each wait cycle adds 1.
//  imem_ready outside FETCH and ex_done outside EXECUTE are ignored.
//  branch_taken is ignored for non-branch opcodes.
//  Reset asserted in any state aborts immediately. No ra_we or pc update is issued.
//  Outputs are registered; imem_addr is combinational from pc.
// TESTING
//  T1: reset_n low, then release -> pc=0, imem_req=1, instr_valid=ra_we=addr_err=0.
//  T2: ALU op (ir=32'h0000_0020) from pc=0x0000_0010, ready/done immediate -> pc=0x14 after 4 cycles;
//      imem_ready held low 3 cycles -> 7 cycles.
//  T3: pc=0x3000_0000, J ir=32'h0AD5_C43F -> pc=0x3B57_10FC.
//  T4: JAL from pc=0x0040_0000, ir=32'h0C00_0004 -> ra_we pulse with ra_data=0x0040_0004, pc=0x0000_0010.
//  T5: BEQ imm=16'hFFFF at pc=0x100 -> taken: pc=0x100; not taken: pc=0x104.
//      BNE imm=16'h0003 taken -> pc=0x110.
//  T6: JR with reg_rs=0x0000_2002 -> addr_err pulse, pc=0x2000.
//      reset_n low while in EXECUTE -> pc=RESET_PC, no ra_we; pc=0xFFFF_FFFC ALU op -> pc=0x0.

Source files
------------

// File: rtl/jump_pc_sequencer_if.sv
// Bus between the next-PC sequencer, instruction memory and the datapath.
//   master : the sequencer (drives fetch request/address, ir, pc, link write, error)
//   slave  : the environment (imem responses, execute completion, branch result, rs value)
interface jump_pc_sequencer_if;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_ready;
  logic [31:0] imem_data;
  logic [31:0] ir;
  logic        instr_valid;
  logic        ex_done;
  logic        branch_taken;
  logic [31:0] reg_rs;
  logic        ra_we;
  logic [31:0] ra_data;
  logic [31:0] pc;
  logic        addr_err;

  modport master (
    output imem_addr, imem_req, ir, instr_valid, ra_we, ra_data, pc, addr_err,
    input  imem_ready, imem_data, ex_done, branch_taken, reg_rs
  );
  modport slave (
    input  imem_addr, imem_req, ir, instr_valid, ra_we, ra_data, pc, addr_err,
    output imem_ready, imem_data, ex_done, branch_taken, reg_rs
  );
endinterface

// File: rtl/jump_pc_sequencer.sv
// Multicycle next-PC controller: owns the PC, fetches, and steps each
// instruction through FETCH -> DECODE -> EXECUTE -> UPDATE. Resolves J/JAL,
// JR and BEQ/BNE targets and issues the $ra link write for JAL.
// Ports:
//   clk, reset_n : clock, async active-low reset
//   bus (master) : imem_addr/imem_req/imem_ready/imem_data fetch handshake,
//                  ir/instr_valid to datapath, ex_done/branch_taken/reg_rs
//                  from datapath, ra_we/ra_data link write, pc, addr_err.
module jump_pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset_n,
  jump_pc_sequencer_if.master bus
);
  typedef enum logic [1:0] {FETCH, DECODE, EXECUTE, UPDATE} state_t;

  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;
  localparam logic [5:0] FN_JR  = 6'h08;

  state_t      state;
  logic [31:0] pc_q, ir_q, ra_data_q;
  logic        imem_req_q, instr_valid_q, ra_we_q, addr_err_q;
  logic        taken_q;
  logic [31:2] rs_q;     // JR target captured together with ex_done

  logic [31:0] pc_plus4, jump_tgt, br_tgt, jr_tgt, nxt_pc;
  logic        is_j, is_jal, is_br, is_jr;

  assign pc_plus4 = pc_q + 32'd4;
  assign jump_tgt = {pc_plus4[31:28], ir_q[25:0], 2'b00};
  assign br_tgt   = pc_plus4 + {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
  assign jr_tgt   = {rs_q, 2'b00};

  assign is_j   = (ir_q[31:26] == OP_J);
  assign is_jal = (ir_q[31:26] == OP_JAL);
  assign is_br  = (ir_q[31:26] == OP_BEQ) || (ir_q[31:26] == OP_BNE);
  assign is_jr  = (ir_q[31:26] == 6'h00) && (ir_q[5:0] == FN_JR);

  always_comb begin
    nxt_pc = pc_plus4;
    if (is_j || is_jal)       nxt_pc = jump_tgt;
    else if (is_jr)           nxt_pc = jr_tgt;
    else if (is_br && taken_q) nxt_pc = br_tgt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= FETCH;
      pc_q          <= RESET_PC;
      ir_q          <= '0;
      ra_data_q     <= '0;
      imem_req_q    <= 1'b1;
      instr_valid_q <= 1'b0;
      ra_we_q       <= 1'b0;
      addr_err_q    <= 1'b0;
      taken_q       <= 1'b0;
      rs_q          <= '0;
    end else begin
      // single-cycle pulses default low
      instr_valid_q <= 1'b0;
      ra_we_q       <= 1'b0;
      addr_err_q    <= 1'b0;
      case (state)
        FETCH: if (bus.imem_ready) begin
          ir_q          <= bus.imem_data;
          instr_valid_q <= 1'b1;
          imem_req_q    <= 1'b0;
          state         <= DECODE;
        end
        DECODE: state <= EXECUTE;
        EXECUTE: if (bus.ex_done) begin
          taken_q <= bus.branch_taken;
          rs_q    <= bus.reg_rs[31:2];
          // link/err pulses are registered, so they are set on entry to UPDATE
          if (is_jal) begin
            ra_we_q   <= 1'b1;
            ra_data_q <= pc_plus4;
          end
          if (is_jr && (bus.reg_rs[1:0] != 2'b00)) addr_err_q <= 1'b1;
          state <= UPDATE;
        end
        UPDATE: begin
          pc_q       <= nxt_pc;
          imem_req_q <= 1'b1;
          state      <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.pc          = pc_q;
  assign bus.imem_req    = imem_req_q;
  assign bus.ir          = ir_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.ra_we       = ra_we_q;
  assign bus.ra_data     = ra_data_q;
  assign bus.addr_err    = addr_err_q;
endmodule

// File: tb/tb_jump_pc_sequencer.sv
module tb_jump_pc_sequencer;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  jump_pc_sequencer_if bus ();
  jump_pc_sequencer #(.RESET_PC(32'h0)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  typedef struct {
    logic [31:0] pc;
    logic        ra_we;
    logic [31:0] ra_data;
    logic        err;
    int          cycles;
  } exp_t;

  exp_t q[$];
  int nvec = 0, nfail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: an instruction completes when imem_req rises again (next FETCH).
  initial begin
    bit started = 0, prev_req = 0, ra_seen = 0, err_seen = 0;
    logic [31:0] ra_d = '0;
    int cyc = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        started = 0; prev_req = 0;
      end else begin
        if (bus.imem_req && !prev_req) begin
          if (started) begin
            if (q.size() == 0) begin
              nvec++; nfail++;
              $display("FAIL unexpected_completion: pc %h with no expected entry", bus.pc);
            end else begin
              e = q.pop_front();
              chk("pc", bus.pc, e.pc);
              chk("ra_we", {31'b0, ra_seen}, {31'b0, e.ra_we});
              if (e.ra_we) chk("ra_data", ra_d, e.ra_data);
              chk("addr_err", {31'b0, err_seen}, {31'b0, e.err});
              chk("cycles", cyc, e.cycles);
            end
          end
          started = 1; cyc = 0; ra_seen = 0; err_seen = 0;
        end
        cyc++;
        if (bus.ra_we) begin ra_seen = 1; ra_d = bus.ra_data; end
        if (bus.addr_err) err_seen = 1;
        prev_req = bus.imem_req;
      end
    end
  end

  task automatic wait_fetch();
    int n = 0;
    while (!bus.imem_req && n < 50) begin @(negedge clk); n++; end
    if (!bus.imem_req) begin
      nvec++; nfail++;
      $display("FAIL fetch_timeout: imem_req %b expected 1", bus.imem_req);
    end
  endtask

  // Runs one instruction; called at a negedge, returns at the negedge in the next FETCH.
  task automatic exec(input logic [31:0] instr, input logic [31:0] rs, input logic tk,
                      input int fw, input int ew,
                      input logic [31:0] epc, input logic ewe, input logic [31:0] ead,
                      input logic eerr);
    exp_t e;
    e.pc = epc; e.ra_we = ewe; e.ra_data = ead; e.err = eerr; e.cycles = 4 + fw + ew;
    q.push_back(e);
    wait_fetch();
    bus.imem_data = instr;
    bus.ex_done = (fw > 0);          // must be ignored outside EXECUTE
    repeat (fw) @(negedge clk);
    bus.imem_ready = 1'b1;
    @(negedge clk);                  // DECODE
    bus.imem_ready = 1'b0; bus.ex_done = 1'b0;
    bus.imem_data = 32'hDEAD_BEEF;
    @(negedge clk);                  // EXECUTE
    bus.reg_rs = rs; bus.branch_taken = tk;
    repeat (ew) @(negedge clk);
    bus.ex_done = 1'b1;
    @(negedge clk);                  // UPDATE
    bus.ex_done = 1'b0; bus.branch_taken = 1'b0;
    @(negedge clk);                  // FETCH
  endtask

  localparam logic [31:0] ALU = 32'h0000_0020;
  localparam logic [31:0] JR  = 32'h03E0_0008;

  task automatic set_pc(input logic [31:0] v);
    exec(JR, v, 1'b0, 0, 0, v, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 50) begin @(negedge clk); n++; end
    chk("drain_queue_empty", q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.imem_ready = 0; bus.imem_data = 0; bus.ex_done = 0;
    bus.branch_taken = 0; bus.reg_rs = 0;
    repeat (3) @(negedge clk);
    // T1: reset state
    chk("rst_pc", bus.pc, 32'h0);
    chk("rst_imem_addr", bus.imem_addr, 32'h0);
    chk("rst_imem_req", {31'b0, bus.imem_req}, 32'h1);
    chk("rst_instr_valid", {31'b0, bus.instr_valid}, 32'h0);
    chk("rst_ra_we", {31'b0, bus.ra_we}, 32'h0);
    chk("rst_addr_err", {31'b0, bus.addr_err}, 32'h0);
    chk("rst_ir", bus.ir, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // T2: ALU ops, immediate and with 3 fetch wait cycles
    set_pc(32'h0000_0010);
    exec(ALU, 0, 0, 0, 0, 32'h0000_0014, 0, 0, 0);
    exec(ALU, 0, 0, 3, 0, 32'h0000_0018, 0, 0, 0);
    // T3: J
    set_pc(32'h3000_0000);
    exec(32'h0AD5_C43F, 0, 0, 0, 0, 32'h3B57_10FC, 0, 0, 0);
    // T4: JAL
    set_pc(32'h0040_0000);
    exec(32'h0C00_0004, 0, 0, 0, 0, 32'h0000_0010, 1, 32'h0040_0004, 0);
    // T5: branches
    set_pc(32'h0000_0100);
    exec(32'h1000_FFFF, 0, 1, 0, 0, 32'h0000_0100, 0, 0, 0);
    exec(32'h1000_FFFF, 0, 0, 0, 0, 32'h0000_0104, 0, 0, 0);
    set_pc(32'h0000_0100);
    exec(32'h1400_0003, 0, 1, 0, 0, 32'h0000_0110, 0, 0, 0);
    exec(32'h1400_0003, 0, 0, 0, 2, 32'h0000_0114, 0, 0, 0);
    exec(ALU, 0, 1, 0, 0, 32'h0000_0118, 0, 0, 0);   // branch_taken ignored
    // T6: misaligned JR, wrap
    exec(JR, 32'h0000_2002, 0, 0, 0, 32'h0000_2000, 0, 0, 1);
    set_pc(32'hFFFF_FFFC);
    exec(ALU, 0, 0, 0, 0, 32'h0000_0000, 0, 0, 0);
    drain();

    // Reset during EXECUTE of a JAL: abort, no link write
    set_pc(32'h0040_0000);
    drain();
    wait_fetch();
    bus.imem_data = 32'h0C00_0004; bus.imem_ready = 1'b1;
    @(negedge clk);
    bus.imem_ready = 1'b0;
    @(negedge clk);                  // EXECUTE
    bus.ex_done = 1'b1;
    #2 reset_n = 1'b0;               // async, before the rising edge
    #1;
    chk("abort_pc", bus.pc, 32'h0);
    chk("abort_imem_req", {31'b0, bus.imem_req}, 32'h1);
    @(negedge clk);
    chk("abort_ra_we", {31'b0, bus.ra_we}, 32'h0);
    chk("abort_ra_data", bus.ra_data, 32'h0);
    bus.ex_done = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    exec(ALU, 0, 0, 0, 0, 32'h0000_0004, 0, 0, 0);
    @(negedge clk);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
